// File: rtl/serial_quotient_div.sv
// Bit-serial restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock (MSB first), parallel quotient and remainder at completion.
module serial_quotient_div #(
   parameter int W = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [2*W-1:0]           P_in,
   input  logic [W-1:0]             Y,
   output logic                     busy,
   output logic                     q,
   output logic                     q_valid,
   output logic [W-1:0]             Q,
   output logic [W-1:0]             R,
   output logic                     done,
   output logic                     div_by_zero,
   output logic                     overflow,
   output logic [$clog2(W+1)-1:0]   count_out
);

   localparam int CW = $clog2(W+1);

   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   state_t         state_reg, state_next;
   // The partial remainder is always < Y, so W bits hold it between steps;
   // only the trial value needs the extra bit.
   logic [W-1:0]   rem_reg, rem_next;
   // Dividend low half shifts out at the top while quotient bits enter at the bottom.
   logic [W-1:0]   shift_reg, shift_next;
   logic [W-1:0]   y_reg, y_next;
   logic [CW-1:0]  count_reg, count_next;
   logic [W-1:0]   quot_reg, quot_next;
   logic [W-1:0]   rmd_reg, rmd_next;
   logic           busy_reg, busy_next;
   logic           q_reg, q_next;
   logic           q_valid_reg, q_valid_next;
   logic           done_reg, done_next;
   logic           dbz_reg, dbz_next;
   logic           ovf_reg, ovf_next;

   logic [W:0]     trial;
   logic [W-1:0]   diff;
   logic           qbit;

   assign trial = {rem_reg, shift_reg[W-1]};
   assign qbit  = (trial >= {1'b0, y_reg});
   // Only taken when trial >= Y, and the result is < Y, so W bits suffice.
   assign diff  = trial[W-1:0] - y_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         rem_reg     <= '0;
         shift_reg   <= '0;
         y_reg       <= '0;
         count_reg   <= '0;
         quot_reg    <= '0;
         rmd_reg     <= '0;
         busy_reg    <= 1'b0;
         q_reg       <= 1'b0;
         q_valid_reg <= 1'b0;
         done_reg    <= 1'b0;
         dbz_reg     <= 1'b0;
         ovf_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rem_reg     <= rem_next;
         shift_reg   <= shift_next;
         y_reg       <= y_next;
         count_reg   <= count_next;
         quot_reg    <= quot_next;
         rmd_reg     <= rmd_next;
         busy_reg    <= busy_next;
         q_reg       <= q_next;
         q_valid_reg <= q_valid_next;
         done_reg    <= done_next;
         dbz_reg     <= dbz_next;
         ovf_reg     <= ovf_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      rem_next     = rem_reg;
      shift_next   = shift_reg;
      y_next       = y_reg;
      count_next   = count_reg;
      quot_next    = quot_reg;
      rmd_next     = rmd_reg;
      busy_next    = busy_reg;
      q_next       = q_reg;
      q_valid_next = 1'b0;
      done_next    = 1'b0;
      dbz_next     = dbz_reg;
      ovf_next     = ovf_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               y_next     = Y;
               rem_next   = P_in[2*W-1:W];
               shift_next = P_in[W-1:0];
               count_next = '0;
               busy_next  = 1'b1;
               dbz_next   = 1'b0;
               ovf_next   = 1'b0;
               if (Y == '0) begin
                  dbz_next   = 1'b1;
                  state_next = ERR;
               end else if (P_in[2*W-1:W] >= Y) begin
                  ovf_next   = 1'b1;
                  state_next = ERR;
               end else begin
                  state_next = RUN;
               end
            end
         end

         RUN: begin
            rem_next     = qbit ? diff : trial[W-1:0];
            shift_next   = {shift_reg[W-2:0], qbit};
            q_next       = qbit;
            q_valid_next = 1'b1;
            count_next   = count_reg + CW'(1);
            if (count_reg == CW'(W-1)) begin
               quot_next  = {shift_reg[W-2:0], qbit};
               rmd_next   = rem_next;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         end

         ERR: begin
            quot_next  = '1;
            rmd_next   = '0;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   assign busy        = busy_reg;
   assign q           = q_reg;
   assign q_valid     = q_valid_reg;
   assign Q           = quot_reg;
   assign R           = rmd_reg;
   assign done        = done_reg;
   assign div_by_zero = dbz_reg;
   assign overflow    = ovf_reg;
   assign count_out   = count_reg;

endmodule

// File: tb/tb_serial_quotient_div.sv
// Directed bench for serial_quotient_div (W=6): hand-computed quotients,
// remainders and serial bit streams, checked on the falling edge.
module tb_serial_quotient_div;

   localparam int W = 6;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [2*W-1:0] P_in;
   logic [W-1:0]  Y;
   logic          busy, q, q_valid, done, div_by_zero, overflow;
   logic [W-1:0]  Q, R;
   logic [2:0]    count_out;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   serial_quotient_div #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .P_in(P_in), .Y(Y),
      .busy(busy), .q(q), .q_valid(q_valid), .Q(Q), .R(R), .done(done),
      .div_by_zero(div_by_zero), .overflow(overflow), .count_out(count_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_q"}, 32'(q), 0);
      check({tag, "_qv"}, 32'(q_valid), 0);
      check({tag, "_Q"}, 32'(Q), 0);
      check({tag, "_R"}, 32'(R), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_dbz"}, 32'(div_by_zero), 0);
      check({tag, "_ovf"}, 32'(overflow), 0);
      check({tag, "_cnt"}, 32'(count_out), 0);
   endtask

   // Checks one serial step k (1..W) against the expected quotient eq.
   task automatic check_step(input int k, input logic [W-1:0] eq);
      check($sformatf("qv_%0d", k), 32'(q_valid), 1);
      check($sformatf("q_%0d", k), 32'(q), 32'(eq[W-k]));
      check($sformatf("cnt_%0d", k), 32'(count_out), 32'(k));
      check($sformatf("done_%0d", k), 32'(done), (k == W) ? 1 : 0);
      check($sformatf("busy_%0d", k), 32'(busy), (k == W) ? 0 : 1);
   endtask

   task automatic run_div(input logic [2*W-1:0] p, input logic [W-1:0] y,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input bit e_ovf, input bit e_dbz);
      @(negedge clk);
      start = 1'b1; P_in = p; Y = y;
      @(negedge clk);
      start = 1'b0;
      check("busy_e0", 32'(busy), 1);
      check("cnt_e0", 32'(count_out), 0);
      check("dbz_e0", 32'(div_by_zero), 32'(e_dbz));
      check("ovf_e0", 32'(overflow), 32'(e_ovf));
      if (e_ovf || e_dbz) begin
         @(negedge clk);
         check("err_done", 32'(done), 1);
         check("err_qv", 32'(q_valid), 0);
         check("err_busy", 32'(busy), 0);
         check("err_Q", 32'(Q), 63);
         check("err_R", 32'(R), 0);
         check("err_dbz", 32'(div_by_zero), 32'(e_dbz));
         check("err_ovf", 32'(overflow), 32'(e_ovf));
      end else begin
         for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            check_step(k, eq);
         end
         check("Q", 32'(Q), 32'(eq));
         check("R", 32'(R), 32'(er));
      end
      @(negedge clk);
      check("done_drop", 32'(done), 0);
      check("qv_drop", 32'(q_valid), 0);
      $display("div P=%0d Y=%0d -> Q=%0d R=%0d ovf=%0d dbz=%0d", p, y, Q, R, overflow, div_by_zero);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; P_in = '0; Y = '0;
      repeat (2) @(negedge clk);
      check_all_zero("rst");
      rst_n = 1'b1;

      run_div(12'd78,   6'd13, 6'd6,  6'd0,  1'b0, 1'b0);
      run_div(12'd100,  6'd7,  6'd14, 6'd2,  1'b0, 1'b0);
      run_div(12'd4031, 6'd63, 6'd63, 6'd62, 1'b0, 1'b0);
      run_div(12'd4095, 6'd13, 6'd63, 6'd0,  1'b1, 1'b0);
      run_div(12'd500,  6'd0,  6'd63, 6'd0,  1'b0, 1'b1);
      run_div(12'd78,   6'd13, 6'd6,  6'd0,  1'b0, 1'b0);

      // Asynchronous reset in the middle of a 100/7 run.
      @(negedge clk);
      start = 1'b1; P_in = 12'd100; Y = 6'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      repeat (2) begin
         @(negedge clk);
         check("midrst_done", 32'(done), 0);
      end
      rst_n = 1'b1;
      $display("reset asserted mid-run, outputs cleared");
      run_div(12'd100, 6'd7, 6'd14, 6'd2, 1'b0, 1'b0);

      // start held high: second run taken on the done cycle, mid-run input changes ignored.
      @(negedge clk);
      start = 1'b1; P_in = 12'd78; Y = 6'd13;
      @(negedge clk);
      check("b2b_busy0", 32'(busy), 1);
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         check_step(k, 6'd6);
         if (k == 2) begin P_in = 12'd999; Y = 6'd1; end
         if (k == W) begin P_in = 12'd100; Y = 6'd7; end
      end
      check("b2b_Q1", 32'(Q), 6);
      check("b2b_R1", 32'(R), 0);
      $display("div P=78 Y=13 (held start) -> Q=%0d R=%0d", Q, R);
      @(negedge clk);
      check("b2b_busy1", 32'(busy), 1);
      check("b2b_done_drop", 32'(done), 0);
      check("b2b_cnt0", 32'(count_out), 0);
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         check_step(k, 6'd14);
         if (k == W) start = 1'b0;
      end
      check("b2b_Q2", 32'(Q), 14);
      check("b2b_R2", 32'(R), 2);
      $display("div P=100 Y=7 (back-to-back) -> Q=%0d R=%0d", Q, R);
      @(negedge clk);
      check("b2b_idle_busy", 32'(busy), 0);
      check("b2b_idle_done", 32'(done), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
